// File: rtl/pattern_gen.sv
// pattern_gen: background pattern generator for the VGA demoscene pipeline.
// Consumes the timing block's pixel position / vsync and produces registered
// per-channel colour. Keeps a frame counter and a pattern mode that only ever
// changes on the rising edge of vsync, so a frame is never drawn in two modes.
module pattern_gen #(
  parameter int CB          = 2,    // colour bits per channel (1..4)
  parameter int POS_W       = 10,   // position / frame counter width
  parameter int AUTO_FRAMES = 120   // frames per mode in auto-cycle mode
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [POS_W-1:0]  hpos,
  input  logic [POS_W-1:0]  vpos,
  input  logic              visible,
  input  logic              vsync,
  input  logic [3:0]        mode_sel,
  input  logic              auto_en,
  input  logic [3*CB-1:0]   solid_color,
  output logic [CB-1:0]     R,
  output logic [CB-1:0]     G,
  output logic [CB-1:0]     B,
  output logic [3:0]        mode,
  output logic [POS_W-1:0]  frame_cnt
);

  localparam int CW = 3 * CB;
  localparam int DW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(AUTO_FRAMES - 1);

  // Scroll patterns read mx/my bits up to 7 and stripes read CW bits of the
  // position, so these bounds keep every slice in range.
  if (CB < 1 || CB > 4 || CW > POS_W || POS_W < 8 || AUTO_FRAMES < 1) begin : g_bad_params
    $error("pattern_gen: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    M_SOLID     = 4'd0,
    M_VSTRIPE   = 4'd1,
    M_HSTRIPE   = 4'd2,
    M_SCROLL_XP = 4'd3,
    M_SCROLL_XM = 4'd4,
    M_SCROLL_YP = 4'd5,
    M_SCROLL_YM = 4'd6,
    M_DIAG_PP   = 4'd7,
    M_DIAG_MP   = 4'd8,
    M_DIAG_PM   = 4'd9,
    M_DIAG_MM   = 4'd10,
    M_CHECKER   = 4'd11
  } mode_e;

  // Registered state
  logic              vsync_d;
  logic [POS_W-1:0]  frame_cnt_q;
  mode_e             mode_q;
  logic [DW-1:0]     dwell_q;
  logic [CW-1:0]     pix_q;

  // Combinational next-state / datapath
  logic              frame_tick;
  mode_e             mode_next;
  logic [DW-1:0]     dwell_next;
  logic [POS_W-1:0]  mx_add, mx_sub, my_add, my_sub;
  logic [CW-1:0]     pix_next;

  // Build a scroll-pattern word: channel c (R=0, G=1, B=2) takes src[5+c] as
  // its MSB and replicates fill_bit into the remaining CB-1 bits.
  function automatic logic [CW-1:0] scroll_word(input logic [POS_W-1:0] src,
                                                input logic             fill_bit);
    logic [CW-1:0] w;
    w = '0;
    for (int c = 0; c < 3; c++) begin
      w[(3-c)*CB-1] = src[5+c];
      for (int k = 0; k < CB-1; k++) begin
        w[(2-c)*CB+k] = fill_bit;
      end
    end
    return w;
  endfunction

  assign frame_tick = vsync & ~vsync_d;

  // Decide the mode and dwell count to load on the next frame tick.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    mode_next  = mode_q;
    dwell_next = dwell_q;
    if (!auto_en) begin
      mode_next  = (mode_sel <= 4'd11) ? mode_e'(mode_sel) : M_SOLID;
      dwell_next = '0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_next = '0;
      mode_next  = (mode_q >= M_CHECKER) ? M_SOLID : mode_e'(mode_q + 4'd1);
    end else begin
      dwell_next = dwell_q + DW'(1);
    end
  end

  // Scrolled coordinates, using the frame count registered before this edge.
  always_comb begin
    mx_add = hpos + frame_cnt_q;
    mx_sub = hpos - frame_cnt_q;
    my_add = vpos + frame_cnt_q;
    my_sub = vpos - frame_cnt_q;
  end

  // Pattern decode for the current pixel; blanked outside the active region.
  always_comb begin
    pix_next = '0;
    case (mode_q)
      M_SOLID:     pix_next = solid_color;
      M_VSTRIPE:   pix_next = hpos[CW-1:0];
      M_HSTRIPE:   pix_next = vpos[CW-1:0];
      M_SCROLL_XP: pix_next = scroll_word(mx_add, vpos[2]);
      M_SCROLL_XM: pix_next = scroll_word(mx_sub, vpos[2]);
      M_SCROLL_YP: pix_next = scroll_word(my_add, vpos[2]);
      M_SCROLL_YM: pix_next = scroll_word(my_sub, vpos[2]);
      M_DIAG_PP:   pix_next = scroll_word(my_add, mx_add[2]);
      M_DIAG_MP:   pix_next = scroll_word(my_add, mx_sub[2]);
      M_DIAG_PM:   pix_next = scroll_word(my_sub, mx_add[2]);
      M_DIAG_MM:   pix_next = scroll_word(my_sub, mx_sub[2]);
      M_CHECKER:   pix_next = (hpos[5] ^ vpos[5]) ? solid_color : ~solid_color;
      default:     pix_next = '0;
    endcase
    if (!visible) begin
      pix_next = '0;
    end
  end

  // Frame/mode state and registered colour; reset dominates everything.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, e.g. the pixel uses the old mode on a tick.
    if (!rst_n) begin
      vsync_d     <= 1'b0;
      frame_cnt_q <= '0;
      mode_q      <= M_SOLID;
      dwell_q     <= '0;
      pix_q       <= '0;
    end else begin
      vsync_d <= vsync;
      if (frame_tick) begin
        frame_cnt_q <= frame_cnt_q + POS_W'(1);
        mode_q      <= mode_next;
        dwell_q     <= dwell_next;
      end
      pix_q <= pix_next;
    end
  end

  assign R         = pix_q[3*CB-1:2*CB];
  assign G         = pix_q[2*CB-1:CB];
  assign B         = pix_q[CB-1:0];
  assign mode      = mode_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed and randomized checks of pattern_gen against a
// behavioural model built from integer arithmetic on the pattern rules.
module tb_pattern_gen;

  localparam int CB  = 2;
  localparam int PW  = 10;
  localparam int AF  = 2;
  localparam int MODV = 1 << PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] hpos, vpos;
  logic          visible, vsync, auto_en;
  logic [3:0]    mode_sel;
  logic [5:0]    solid_color;
  logic [1:0]    R, G, B;
  logic [3:0]    mode;
  logic [PW-1:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  // Model state
  int         m_vsd, m_fc, m_mode, m_dwell;
  logic [5:0] exp_rgb;

  pattern_gen #(.CB(CB), .POS_W(PW), .AUTO_FRAMES(AF)) dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .visible(visible),
    .vsync(vsync), .mode_sel(mode_sel), .auto_en(auto_en),
    .solid_color(solid_color), .R(R), .G(G), .B(B), .mode(mode),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic int bitof(int v, int b);
    return (v >> b) & 1;
  endfunction

  // Expected {R,G,B} for one pixel given the mode and frame count in effect.
  function automatic logic [5:0] ref_pixel(int md, int fc, int h, int v,
                                           logic vis, logic [5:0] solid);
    int xp, xm, yp, ym, src, fill, word;
    if (!vis) return 6'd0;
    xp = (h + fc) % MODV;
    xm = (h - fc + MODV) % MODV;
    yp = (v + fc) % MODV;
    ym = (v - fc + MODV) % MODV;
    src = 0; fill = 0;
    case (md)
      0:  return solid;
      1:  return 6'(h % 64);
      2:  return 6'(v % 64);
      3:  begin src = xp; fill = bitof(v, 2);  end
      4:  begin src = xm; fill = bitof(v, 2);  end
      5:  begin src = yp; fill = bitof(v, 2);  end
      6:  begin src = ym; fill = bitof(v, 2);  end
      7:  begin src = yp; fill = bitof(xp, 2); end
      8:  begin src = yp; fill = bitof(xm, 2); end
      9:  begin src = ym; fill = bitof(xp, 2); end
      10: begin src = ym; fill = bitof(xm, 2); end
      11: return (bitof(h, 5) != bitof(v, 5)) ? solid : ~solid;
      default: return 6'd0;
    endcase
    word = 0;
    for (int c = 0; c < 3; c++) begin
      word += (bitof(src, 5 + c) * 2 + fill) << (2 * (2 - c));
    end
    return 6'(word);
  endfunction

  // Advance the model by one clock, then let the DUT take the same edge.
  task automatic cycle();
    if (!rst_n) begin
      m_vsd = 0; m_fc = 0; m_mode = 0; m_dwell = 0; exp_rgb = 6'd0;
    end else begin
      exp_rgb = ref_pixel(m_mode, m_fc, int'(hpos), int'(vpos), visible, solid_color);
      if (vsync && m_vsd == 0) begin
        m_fc = (m_fc + 1) % MODV;
        if (!auto_en) begin
          m_mode  = (mode_sel <= 4'd11) ? int'(mode_sel) : 0;
          m_dwell = 0;
        end else if (m_dwell == AF - 1) begin
          m_dwell = 0;
          m_mode  = (m_mode >= 11) ? 0 : m_mode + 1;
        end else begin
          m_dwell = m_dwell + 1;
        end
      end
      m_vsd = vsync ? 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse(int high_cycles);
    vsync = 1'b1;
    repeat (high_cycles) cycle();
    vsync = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vsync = i[0];
      visible = 1'b1;
      cycle();
      total++;
      if ({R, G, B} !== 6'd0 || mode !== 4'd0 || frame_cnt !== '0) begin
        bad++;
        $display("FAIL reset_hold rgb=%h mode=%0d fc=%0d required all zero", {R, G, B}, mode, frame_cnt);
      end
    end
    vsync = 1'b0;
    rst_n = 1'b1;
    cycle();
    total++;
    if (frame_cnt !== PW'(m_fc) || frame_cnt !== '0) begin
      bad++;
      $display("FAIL reset_release fc=%0d required 0", frame_cnt);
    end
  endtask

  task automatic test_solid();
    mode_sel = 4'd0; auto_en = 1'b0; solid_color = 6'b110000;
    hpos = 10'd17; vpos = 10'd9; visible = 1'b1;
    frame_pulse(1);
    cycle();
    total++;
    if (R !== 2'b11 || G !== 2'b00 || B !== 2'b00 || {R, G, B} !== exp_rgb) begin
      bad++;
      $display("FAIL solid rgb=%b required=%b", {R, G, B}, exp_rgb);
    end
    visible = 1'b0;
    cycle();
    total++;
    if ({R, G, B} !== 6'd0) begin
      bad++;
      $display("FAIL blank rgb=%b required 000000", {R, G, B});
    end
  endtask

  task automatic test_frame_count();
    int base;
    base = m_fc;
    for (int i = 0; i < 3; i++) frame_pulse(5);
    total++;
    if (frame_cnt !== PW'(m_fc) || m_fc != base + 3) begin
      bad++;
      $display("FAIL frame_count fc=%0d required=%0d", frame_cnt, base + 3);
    end
    mode_sel = 4'd1;
    repeat (4) cycle();
    total++;
    if (mode !== 4'd0) begin
      bad++;
      $display("FAIL mode_hold mode=%0d required 0", mode);
    end
    frame_pulse(1);
    total++;
    if (mode !== 4'd1) begin
      bad++;
      $display("FAIL mode_switch mode=%0d required 1", mode);
    end
    hpos = 10'h02D; vpos = 10'd3; visible = 1'b1;
    cycle();
    total++;
    if ({R, G, B} !== 6'b101101 || {R, G, B} !== exp_rgb) begin
      bad++;
      $display("FAIL vstripe rgb=%b required 101101", {R, G, B});
    end
  endtask

  task automatic test_scroll();
    mode_sel = 4'd3;
    for (int i = 0; i < 2048 && !(m_fc == 32 && m_mode == 3); i++) frame_pulse(1);
    hpos = 10'd0; vpos = 10'd4; visible = 1'b1;
    cycle();
    total++;
    if ({R, G, B} !== 6'b110101 || mode !== 4'd3 || frame_cnt !== 10'd32) begin
      bad++;
      $display("FAIL scroll_xp rgb=%b mode=%0d fc=%0d required 110101/3/32", {R, G, B}, mode, frame_cnt);
    end
    // Walk the counter all the way round so mode 4 lands on frame 32 too.
    mode_sel = 4'd4;
    for (int i = 0; i < 2048 && !(m_fc == 32 && m_mode == 4); i++) frame_pulse(1);
    hpos = 10'd0; vpos = 10'd4; visible = 1'b1;
    cycle();
    total++;
    if ({R, G, B} !== 6'b111111 || mode !== 4'd4 || frame_cnt !== 10'd32) begin
      bad++;
      $display("FAIL scroll_xm rgb=%b mode=%0d fc=%0d required 111111/4/32", {R, G, B}, mode, frame_cnt);
    end
  endtask

  task automatic test_auto();
    auto_en = 1'b0; mode_sel = 4'd11;
    frame_pulse(1);
    auto_en = 1'b1; mode_sel = 4'd5;
    frame_pulse(1);
    frame_pulse(1);
    total++;
    if (mode !== 4'd0) begin
      bad++;
      $display("FAIL auto_wrap mode=%0d required 0", mode);
    end
    frame_pulse(1);
    total++;
    if (mode !== 4'd0) begin
      bad++;
      $display("FAIL auto_dwell mode=%0d required 0", mode);
    end
    frame_pulse(1);
    total++;
    if (mode !== 4'd1) begin
      bad++;
      $display("FAIL auto_step mode=%0d required 1", mode);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_illegal_and_reset();
    mode_sel = 4'd13;
    frame_pulse(1);
    total++;
    if (mode !== 4'd0) begin
      bad++;
      $display("FAIL illegal_sel mode=%0d required 0", mode);
    end
    mode_sel = 4'd7;
    frame_pulse(1);
    hpos = 10'd100; vpos = 10'd200; visible = 1'b1; solid_color = 6'h2A;
    cycle();
    total++;
    if (mode !== 4'd7 || {R, G, B} !== exp_rgb) begin
      bad++;
      $display("FAIL diag_pp rgb=%b mode=%0d required %b/7", {R, G, B}, mode, exp_rgb);
    end
    rst_n = 1'b0;
    cycle();
    total++;
    if ({R, G, B} !== 6'd0 || mode !== 4'd0 || frame_cnt !== '0) begin
      bad++;
      $display("FAIL midline_reset rgb=%b mode=%0d fc=%0d required zero", {R, G, B}, mode, frame_cnt);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      hpos        = PW'($urandom);
      vpos        = PW'($urandom);
      visible     = ($urandom_range(0, 3) != 0);
      vsync       = ($urandom_range(0, 3) == 0);
      solid_color = 6'($urandom);
      mode_sel    = 4'($urandom);
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      cycle();
      total++;
      if ({R, G, B} !== exp_rgb || mode !== 4'(m_mode) || frame_cnt !== PW'(m_fc)) begin
        bad++;
        $display("FAIL random[%0d] rgb=%b mode=%0d fc=%0d required %b/%0d/%0d",
                 i, {R, G, B}, mode, frame_cnt, exp_rgb, m_mode, m_fc);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hpos = '0; vpos = '0; visible = 1'b0; vsync = 1'b0;
    mode_sel = 4'd0; auto_en = 1'b0; solid_color = 6'd0;
    m_vsd = 0; m_fc = 0; m_mode = 0; m_dwell = 0; exp_rgb = 6'd0;
    @(negedge clk);
    test_reset();
    test_solid();
    test_frame_count();
    test_scroll();
    test_auto();
    test_illegal_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
